// File: rtl/aq_hpcp_event_cnt_pkg.sv
// Shared HPCP definitions: default counter geometry and the counter word type.
package aq_hpcp_event_cnt_pkg;

  localparam int unsigned HPCP_CNT_WIDTH = 64;
  localparam int unsigned HPCP_EVT_W     = 2;

  typedef logic [HPCP_CNT_WIDTH-1:0] hpcp_cnt_t;

endpackage

// File: rtl/aq_hpcp_evt_stage.sv
// Event capture stage: gates the per-cycle event report by inhibit and registers it.
module aq_hpcp_evt_stage
  import aq_hpcp_event_cnt_pkg::*;
#(
  parameter int unsigned EVT_W = HPCP_EVT_W
) (
  input  logic             hpcp_clk,
  input  logic             cpurst,
  input  logic             event_vld,
  input  logic [EVT_W-1:0] event_num,
  input  logic             cnt_inhibit,
  output logic [EVT_W-1:0] inc_q
);

  // Inhibit only masks new reports; whatever is already captured still drains.
  always_ff @(posedge hpcp_clk) begin
    if (cpurst) begin
      inc_q <= '0;
    end else if (event_vld && !cnt_inhibit) begin
      inc_q <= event_num;
    end else begin
      inc_q <= '0;
    end
  end

endmodule

// File: rtl/aq_hpcp_event_cnt.sv
// HPCP event counter: two-stage pipeline (event capture, then accumulate) with
// CSR write override and a one-cycle registered overflow pulse.
module aq_hpcp_event_cnt
  import aq_hpcp_event_cnt_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = HPCP_CNT_WIDTH,
  parameter int unsigned EVT_W     = HPCP_EVT_W
) (
  input  logic                 hpcp_clk,
  input  logic                 cpurst,
  input  logic                 event_vld,
  input  logic [EVT_W-1:0]     event_num,
  input  logic                 cnt_inhibit,
  input  logic                 cnt_wen,
  input  logic [CNT_WIDTH-1:0] cnt_wdata,
  output logic [CNT_WIDTH-1:0] cnt_value,
  output logic                 counter_overflow_x
);

  logic [EVT_W-1:0]   inc_q;
  logic [CNT_WIDTH:0] sum_c;

  aq_hpcp_evt_stage #(
    .EVT_W (EVT_W)
  ) u_evt_stage (
    .hpcp_clk    (hpcp_clk),
    .cpurst      (cpurst),
    .event_vld   (event_vld),
    .event_num   (event_num),
    .cnt_inhibit (cnt_inhibit),
    .inc_q       (inc_q)
  );

  // Single adder, fed only from registers; top bit is the wrap carry.
  assign sum_c = {1'b0, cnt_value} + (CNT_WIDTH+1)'(inc_q);

  // A CSR write wins over the pending increment and suppresses the overflow.
  always_ff @(posedge hpcp_clk) begin
    if (cpurst) begin
      cnt_value          <= '0;
      counter_overflow_x <= 1'b0;
    end else if (cnt_wen) begin
      cnt_value          <= cnt_wdata;
      counter_overflow_x <= 1'b0;
    end else begin
      cnt_value          <= sum_c[CNT_WIDTH-1:0];
      counter_overflow_x <= sum_c[CNT_WIDTH];
    end
  end

endmodule

// File: tb/tb_aq_hpcp_event_cnt.sv
// Directed self-checking bench for aq_hpcp_event_cnt at default parameters.
module tb_aq_hpcp_event_cnt;
  import aq_hpcp_event_cnt_pkg::*;

  logic       hpcp_clk;
  logic       cpurst;
  logic       event_vld;
  logic [1:0] event_num;
  logic       cnt_inhibit;
  logic       cnt_wen;
  hpcp_cnt_t  cnt_wdata;
  hpcp_cnt_t  cnt_value;
  logic       counter_overflow_x;

  int n_checks = 0;
  int n_pass   = 0;

  localparam hpcp_cnt_t ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  aq_hpcp_event_cnt dut (
    .hpcp_clk           (hpcp_clk),
    .cpurst             (cpurst),
    .event_vld          (event_vld),
    .event_num          (event_num),
    .cnt_inhibit        (cnt_inhibit),
    .cnt_wen            (cnt_wen),
    .cnt_wdata          (cnt_wdata),
    .cnt_value          (cnt_value),
    .counter_overflow_x (counter_overflow_x)
  );

  initial hpcp_clk = 1'b0;
  always #5 hpcp_clk = ~hpcp_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  // One clock edge with the currently driven inputs; outputs sampled 1ns later.
  task automatic step();
    @(posedge hpcp_clk);
    #1;
  endtask

  task automatic test_reset();
    cpurst = 1'b1; event_vld = 1'b1; event_num = 2'd3;
    cnt_wen = 1'b1; cnt_wdata = 64'h1234; cnt_inhibit = 1'b0;
    step(); step();
    n_checks++;
    if (cnt_value !== 64'd0 || counter_overflow_x !== 1'b0)
      $display("FAIL reset_hold cnt=%0h ovf=%b expected cnt=0 ovf=0", cnt_value, counter_overflow_x);
    else n_pass++;
    cpurst = 1'b0; event_vld = 1'b0; cnt_wen = 1'b0; cnt_wdata = '0;
    step();
    n_checks++;
    if (cnt_value !== 64'd0 || counter_overflow_x !== 1'b0)
      $display("FAIL reset_release cnt=%0h ovf=%b expected cnt=0 ovf=0", cnt_value, counter_overflow_x);
    else n_pass++;
  endtask

  // Four reports of 3 events: visible two edges later as 3,6,9,12.
  task automatic test_count();
    hpcp_cnt_t exp [6];
    exp[0] = 64'd0; exp[1] = 64'd3; exp[2] = 64'd6;
    exp[3] = 64'd9; exp[4] = 64'd12; exp[5] = 64'd12;
    for (int i = 0; i < 6; i++) begin
      event_vld = (i < 4);
      event_num = 2'd3;
      step();
      n_checks++;
      if (cnt_value !== exp[i] || counter_overflow_x !== 1'b0)
        $display("FAIL count[%0d] cnt=%0h ovf=%b expected cnt=%0h ovf=0", i, cnt_value, counter_overflow_x, exp[i]);
      else n_pass++;
    end
    event_vld = 1'b0;
  endtask

  // Write near the top, add 3, expect wrap to 1 with a single overflow cycle.
  task automatic test_wrap();
    hpcp_cnt_t exp_c [5];
    logic      exp_o [5];
    exp_c[0] = 64'hFFFF_FFFF_FFFF_FFFE; exp_o[0] = 1'b0;
    exp_c[1] = 64'hFFFF_FFFF_FFFF_FFFE; exp_o[1] = 1'b0;
    exp_c[2] = 64'd1;                   exp_o[2] = 1'b1;
    exp_c[3] = 64'd1;                   exp_o[3] = 1'b0;
    exp_c[4] = 64'd1;                   exp_o[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cnt_wen   = (i == 0);
      cnt_wdata = 64'hFFFF_FFFF_FFFF_FFFE;
      event_vld = (i == 1);
      event_num = 2'd3;
      step();
      n_checks++;
      if (cnt_value !== exp_c[i] || counter_overflow_x !== exp_o[i])
        $display("FAIL wrap[%0d] cnt=%0h ovf=%b expected cnt=%0h ovf=%b", i, cnt_value, counter_overflow_x, exp_c[i], exp_o[i]);
      else n_pass++;
    end
    cnt_wen = 1'b0; event_vld = 1'b0;
  endtask

  // Pending 2 is dropped by the write; the 1 captured in the write cycle lands after.
  task automatic test_write_discard();
    hpcp_cnt_t exp [4];
    exp[0] = 64'd1; exp[1] = 64'h100; exp[2] = 64'h101; exp[3] = 64'h101;
    for (int i = 0; i < 4; i++) begin
      event_vld = (i < 2);
      event_num = (i == 0) ? 2'd2 : 2'd1;
      cnt_wen   = (i == 1);
      cnt_wdata = 64'h100;
      step();
      n_checks++;
      if (cnt_value !== exp[i] || counter_overflow_x !== 1'b0)
        $display("FAIL write_discard[%0d] cnt=%0h ovf=%b expected cnt=%0h ovf=0", i, cnt_value, counter_overflow_x, exp[i]);
      else n_pass++;
    end
    cnt_wen = 1'b0; event_vld = 1'b0;
  endtask

  // Inhibit stops capture but lets the queued increment drain; writes still land.
  task automatic test_inhibit();
    hpcp_cnt_t exp [7];
    exp[0] = 64'h101; exp[1] = 64'h102; exp[2] = 64'h103; exp[3] = 64'h103;
    exp[4] = 64'h103; exp[5] = 64'h55;  exp[6] = 64'h55;
    event_vld = 1'b1; event_num = 2'd1;
    for (int i = 0; i < 7; i++) begin
      cnt_inhibit = (i >= 2);
      cnt_wen     = (i == 5);
      cnt_wdata   = 64'h55;
      step();
      n_checks++;
      if (cnt_value !== exp[i] || counter_overflow_x !== 1'b0)
        $display("FAIL inhibit[%0d] cnt=%0h ovf=%b expected cnt=%0h ovf=0", i, cnt_value, counter_overflow_x, exp[i]);
      else n_pass++;
    end
    cnt_inhibit = 1'b0; cnt_wen = 1'b0; event_vld = 1'b0;
  endtask

  // Reset on the edge where the wrap would apply: no pulse ever, pending inc dropped.
  task automatic test_reset_mid();
    hpcp_cnt_t exp [5];
    exp[0] = ALL_ONES; exp[1] = ALL_ONES; exp[2] = 64'd0; exp[3] = 64'd0; exp[4] = 64'd0;
    for (int i = 0; i < 5; i++) begin
      cnt_wen   = (i == 0);
      cnt_wdata = ALL_ONES;
      event_vld = (i == 1);
      event_num = 2'd1;
      cpurst    = (i == 2);
      step();
      n_checks++;
      if (cnt_value !== exp[i] || counter_overflow_x !== 1'b0)
        $display("FAIL reset_mid[%0d] cnt=%0h ovf=%b expected cnt=%0h ovf=0", i, cnt_value, counter_overflow_x, exp[i]);
      else n_pass++;
    end
    cpurst = 1'b0; cnt_wen = 1'b0; event_vld = 1'b0;
  endtask

  // All-ones written with no events, then a zero-count report: held, never overflows.
  task automatic test_hold();
    for (int i = 0; i < 6; i++) begin
      cnt_wen   = (i == 0);
      cnt_wdata = ALL_ONES;
      event_vld = (i == 3);
      event_num = 2'd0;
      step();
      n_checks++;
      if (cnt_value !== ALL_ONES || counter_overflow_x !== 1'b0)
        $display("FAIL hold[%0d] cnt=%0h ovf=%b expected cnt=%0h ovf=0", i, cnt_value, counter_overflow_x, ALL_ONES);
      else n_pass++;
    end
    cnt_wen = 1'b0; event_vld = 1'b0;
  endtask

  // Back-to-back reports 3 then 1 from all-ones: remainder 2 kept, then 3.
  task automatic test_back_to_back();
    hpcp_cnt_t exp_c [5];
    logic      exp_o [5];
    exp_c[0] = ALL_ONES; exp_o[0] = 1'b0;
    exp_c[1] = ALL_ONES; exp_o[1] = 1'b0;
    exp_c[2] = 64'd2;    exp_o[2] = 1'b1;
    exp_c[3] = 64'd3;    exp_o[3] = 1'b0;
    exp_c[4] = 64'd3;    exp_o[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cnt_wen   = (i == 0);
      cnt_wdata = ALL_ONES;
      event_vld = (i == 1) || (i == 2);
      event_num = (i == 1) ? 2'd3 : 2'd1;
      step();
      n_checks++;
      if (cnt_value !== exp_c[i] || counter_overflow_x !== exp_o[i])
        $display("FAIL back_to_back[%0d] cnt=%0h ovf=%b expected cnt=%0h ovf=%b", i, cnt_value, counter_overflow_x, exp_c[i], exp_o[i]);
      else n_pass++;
    end
    cnt_wen = 1'b0; event_vld = 1'b0;
  endtask

  initial begin
    cpurst = 1'b1; event_vld = 1'b0; event_num = 2'd0;
    cnt_inhibit = 1'b0; cnt_wen = 1'b0; cnt_wdata = '0;
    test_reset();
    test_count();
    test_wrap();
    test_write_discard();
    test_inhibit();
    test_reset_mid();
    test_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
